messbauer_run_sequencer: RTL and testbench

- Run controller for the two messbauer_generator channels (v1, v2) of the test environment.
- Replaces the free-running power-on reset pulse with a commanded run:
  - holds the selected generators in reset, then releases them;
  - counts velocity frames (rising edges of the generator start strobe) up to a programmed target;
  - returns the generators to reset on completion.
- Sits between the top-level control/debug interface and the generator resets.

---
 rtl/messbauer_seq_pkg.sv | 25 ++
 rtl/messbauer_edge_detector.sv | 26 ++
 rtl/messbauer_run_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_messbauer_run_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/messbauer_seq_pkg.sv
// Shared state encodings and channel-mask bit positions for the run sequencer.
package messbauer_seq_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned V1_BIT  = 0;
  localparam int unsigned V2_BIT  = 1;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    SYNC  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } seq_state_e;

  function automatic logic is_busy(seq_state_e s);
    return (s == HOLD) || (s == SYNC) || (s == RUN);
  endfunction

  function automatic logic is_released(seq_state_e s);
    return (s == SYNC) || (s == RUN);
  endfunction

endpackage

// File: rtl/messbauer_edge_detector.sv
// 1-bit rising-edge detector; clr forces the history flop low so a level
// already high when clr drops is reported as an edge.
module messbauer_edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic rise_c
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = d;
    if (clr) prev_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign rise_c = d & ~prev_q;

endmodule

// File: rtl/messbauer_run_sequencer.sv
// Commanded run controller for the v1/v2 messbauer generators: hold in reset,
// release, count reference frames, re-assert reset. Watchdog: MESSBAUER_SEQ_WATCHDOG_EN.
module messbauer_run_sequencer #(
  parameter int unsigned RESET_HOLD_CYCLES = 16,
  parameter int unsigned FRAMES_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES    = 16777216
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_run,
  input  logic                    cmd_abort,
  input  logic [1:0]              channel_mask,
  input  logic [FRAMES_WIDTH-1:0] frames_target,
  input  logic                    v1_start_in,
  input  logic                    v2_start_in,
  output logic                    v1_areset_n,
  output logic                    v2_areset_n,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [FRAMES_WIDTH-1:0] frames_count,
  output logic [2:0]              state
);

  import messbauer_seq_pkg::*;

  localparam int unsigned HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);

  seq_state_e              state_q,   state_d;
  logic [HOLD_W-1:0]       hold_q,    hold_d;
  logic [1:0]              mask_q,    mask_d;
  logic [FRAMES_WIDTH-1:0] target_q,  target_d;
  logic [FRAMES_WIDTH-1:0] frames_q,  frames_d;
  logic                    v1_rst_n_q, v1_rst_n_d;
  logic                    v2_rst_n_q, v2_rst_n_d;
  logic                    busy_q,    busy_d;
  logic                    done_q,    done_d;
  logic                    error_q,   error_d;

  logic v1_rise_c;
  logic v2_rise_c;
  logic ref_rise_c;
  logic run_ok_c;
  logic hist_clr_c;

  assign hist_clr_c = (state_q == HOLD);

  messbauer_edge_detector u_v1_edge (
    .clk    (aclk),
    .rst    (areset),
    .clr    (hist_clr_c),
    .d      (v1_start_in),
    .rise_c (v1_rise_c)
  );

  messbauer_edge_detector u_v2_edge (
    .clk    (aclk),
    .rst    (areset),
    .clr    (hist_clr_c),
    .d      (v2_start_in),
    .rise_c (v2_rise_c)
  );

  // v1 is the frame reference whenever it takes part in the run
  assign ref_rise_c = mask_q[V1_BIT] ? v1_rise_c : v2_rise_c;
  assign run_ok_c   = cmd_run & ~cmd_abort & (|channel_mask);

`ifdef MESSBAUER_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`else
  logic unused_timeout;
  assign unused_timeout = |32'(TIMEOUT_CYCLES);
`endif

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    mask_d   = mask_q;
    target_d = target_q;
    frames_d = frames_q;
`ifdef MESSBAUER_SEQ_WATCHDOG_EN
    wd_d     = '0;
`endif

    unique case (state_q)
      IDLE: begin
        if (run_ok_c) begin
          mask_d   = channel_mask;
          target_d = frames_target;
          frames_d = '0;
          hold_d   = '0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_W'(RESET_HOLD_CYCLES)) state_d = SYNC;
        else                                      hold_d  = hold_q + HOLD_W'(1);
      end
      SYNC: begin
        if (ref_rise_c) state_d = RUN;
      end
      RUN: begin
        if (ref_rise_c) begin
          frames_d = frames_q + FRAMES_WIDTH'(1);
          if ((target_q != '0) && (frames_d == target_q)) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
`ifdef MESSBAUER_SEQ_WATCHDOG_EN
      ERROR: begin
        if (run_ok_c) begin
          mask_d   = channel_mask;
          target_d = frames_target;
          frames_d = '0;
          hold_d   = '0;
          state_d  = HOLD;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef MESSBAUER_SEQ_WATCHDOG_EN
    // Cycles since the last reference edge while the generators should be running
    if (is_released(state_q) && !ref_rise_c) begin
      if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) state_d = ERROR;
      else                                   wd_d    = wd_q + WD_W'(1);
    end
`endif

    // Abort overrides everything, including a same-cycle frame edge
    if (cmd_abort) begin
      state_d  = IDLE;
      frames_d = frames_q;
    end

    busy_d     = is_busy(state_d);
    done_d     = (state_d == DONE);
    v1_rst_n_d = is_released(state_d) & mask_d[V1_BIT];
    v2_rst_n_d = is_released(state_d) & mask_d[V2_BIT];
`ifdef MESSBAUER_SEQ_WATCHDOG_EN
    error_d    = (state_d == ERROR);
`else
    error_d    = 1'b0;
`endif
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      mask_q     <= '0;
      target_q   <= '0;
      frames_q   <= '0;
      v1_rst_n_q <= 1'b0;
      v2_rst_n_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef MESSBAUER_SEQ_WATCHDOG_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      mask_q     <= mask_d;
      target_q   <= target_d;
      frames_q   <= frames_d;
      v1_rst_n_q <= v1_rst_n_d;
      v2_rst_n_q <= v2_rst_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef MESSBAUER_SEQ_WATCHDOG_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign v1_areset_n  = v1_rst_n_q;
  assign v2_areset_n  = v2_rst_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign frames_count = frames_q;
  assign state        = state_q;

endmodule

// File: tb/tb_messbauer_run_sequencer.sv
// Directed bench for messbauer_run_sequencer (FRAMES_WIDTH=4, 16-cycle hold).
module tb_messbauer_run_sequencer;

  localparam int unsigned FW = 4;

  logic          aclk;
  logic          areset;
  logic          cmd_run;
  logic          cmd_abort;
  logic [1:0]    channel_mask;
  logic [FW-1:0] frames_target;
  logic          v1_start_in;
  logic          v2_start_in;
  logic          v1_areset_n;
  logic          v2_areset_n;
  logic          busy;
  logic          done;
  logic          error;
  logic [FW-1:0] frames_count;
  logic [2:0]    state;

  int total = 0;
  int bad   = 0;

  messbauer_run_sequencer #(
    .RESET_HOLD_CYCLES (16),
    .FRAMES_WIDTH      (FW),
    .TIMEOUT_CYCLES    (200)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cmd_run       (cmd_run),
    .cmd_abort     (cmd_abort),
    .channel_mask  (channel_mask),
    .frames_target (frames_target),
    .v1_start_in   (v1_start_in),
    .v2_start_in   (v2_start_in),
    .v1_areset_n   (v1_areset_n),
    .v2_areset_n   (v2_areset_n),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .frames_count  (frames_count),
    .state         (state)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish within its time budget");
    $fatal(1);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept a run, then check the 17-edge reset release latency
  task automatic start_run(input logic [1:0] m, input logic [FW-1:0] t);
    channel_mask  = m;
    frames_target = t;
    cmd_run       = 1'b1;
    tick();
    cmd_run       = 1'b0;
    channel_mask  = 2'b00;
    frames_target = '0;
    chk("accept_state", 32'(state), 32'd1);
    chk("accept_busy", 32'(busy), 32'd1);
    repeat (16) tick();
    chk("hold_v1_rst", 32'(v1_areset_n), 32'd0);
    chk("hold_v2_rst", 32'(v2_areset_n), 32'd0);
    tick();
    chk("release_state", 32'(state), 32'd2);
    chk("release_v1", 32'(v1_areset_n), 32'(m[0]));
    chk("release_v2", 32'(v2_areset_n), 32'(m[1]));
  endtask

  task automatic pulse_v1(input int gap);
    repeat (gap) tick();
    v1_start_in = 1'b1;
    tick();
    v1_start_in = 1'b0;
  endtask

  initial begin
    areset        = 1'b1;
    cmd_run       = 1'b0;
    cmd_abort     = 1'b0;
    channel_mask  = 2'b00;
    frames_target = '0;
    v1_start_in   = 1'b0;
    v2_start_in   = 1'b0;
    repeat (3) tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_v1", 32'(v1_areset_n), 32'd0);
    chk("rst_v2", 32'(v2_areset_n), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_frames", 32'(frames_count), 32'd0);
    areset = 1'b0;
    tick();

    // Normal run: v1 reference, target 4
    start_run(2'b01, 4'd4);
    pulse_v1(99);
    chk("n_sync_state", 32'(state), 32'd3);
    chk("n_sync_frames", 32'(frames_count), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      pulse_v1(99);
      chk("n_frames", 32'(frames_count), 32'(i));
      chk("n_run_state", 32'(state), 32'd3);
      chk("n_done_low", 32'(done), 32'd0);
    end
    pulse_v1(99);
    chk("n_done", 32'(done), 32'd1);
    chk("n_done_state", 32'(state), 32'd4);
    chk("n_done_frames", 32'(frames_count), 32'd4);
    chk("n_done_v1", 32'(v1_areset_n), 32'd0);
    chk("n_done_busy", 32'(busy), 32'd0);
    tick();
    chk("n_idle_state", 32'(state), 32'd0);
    chk("n_done_pulse", 32'(done), 32'd0);
    chk("n_hold_frames", 32'(frames_count), 32'd4);

    // Reference select: v2 only, v1 toggling as noise
    start_run(2'b10, 4'd2);
    for (int p = 1; p <= 3; p++) begin
      repeat (49) begin
        v1_start_in = ~v1_start_in;
        tick();
      end
      v1_start_in = ~v1_start_in;
      v2_start_in = 1'b1;
      tick();
      v2_start_in = 1'b0;
      chk("r_frames", 32'(frames_count), 32'(p - 1));
      chk("r_done", 32'(done), (p == 3) ? 32'd1 : 32'd0);
    end
    v1_start_in = 1'b0;
    tick();
    chk("r_idle", 32'(state), 32'd0);

    // Abort and ignored commands
    start_run(2'b01, 4'd9);
    pulse_v1(10);
    for (int i = 0; i < 5; i++) pulse_v1(10);
    chk("a_frames5", 32'(frames_count), 32'd5);
    channel_mask  = 2'b11;
    frames_target = 4'd1;
    cmd_run       = 1'b1;
    tick();
    cmd_run       = 1'b0;
    chk("a_busy_run_state", 32'(state), 32'd3);
    chk("a_busy_run_v2", 32'(v2_areset_n), 32'd0);
    chk("a_busy_run_frames", 32'(frames_count), 32'd5);
    cmd_abort   = 1'b1;
    v1_start_in = 1'b1;
    tick();
    cmd_abort   = 1'b0;
    v1_start_in = 1'b0;
    chk("a_abort_state", 32'(state), 32'd0);
    chk("a_abort_frames", 32'(frames_count), 32'd5);
    chk("a_abort_done", 32'(done), 32'd0);
    chk("a_abort_v1", 32'(v1_areset_n), 32'd0);
    chk("a_abort_busy", 32'(busy), 32'd0);
    cmd_run   = 1'b1;
    cmd_abort = 1'b1;
    tick();
    cmd_run   = 1'b0;
    cmd_abort = 1'b0;
    chk("a_both_state", 32'(state), 32'd0);
    channel_mask = 2'b00;
    cmd_run      = 1'b1;
    tick();
    cmd_run      = 1'b0;
    chk("a_mask0_state", 32'(state), 32'd0);
    chk("a_mask0_busy", 32'(busy), 32'd0);

    // Free-run wrap with target 0
    start_run(2'b01, 4'd0);
    pulse_v1(5);
    for (int i = 1; i <= 17; i++) begin
      pulse_v1(5);
      chk("w_frames", 32'(frames_count), 32'(i % 16));
      chk("w_busy", 32'(busy), 32'd1);
    end
    pulse_v1(5);
    pulse_v1(5);
    chk("w_frames3", 32'(frames_count), 32'd3);
    chk("w_error", 32'(error), 32'd0);

    // Asynchronous reset in the middle of a run
    areset = 1'b1;
    #1;
    chk("ar_state", 32'(state), 32'd0);
    chk("ar_v1", 32'(v1_areset_n), 32'd0);
    chk("ar_v2", 32'(v2_areset_n), 32'd0);
    chk("ar_frames", 32'(frames_count), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    tick();
    areset = 1'b0;
    tick();

`ifdef MESSBAUER_SEQ_WATCHDOG_EN
    // No start edges after release: error after 200 cycles in SYNC
    start_run(2'b01, 4'd0);
    repeat (199) tick();
    chk("wd_pre_state", 32'(state), 32'd2);
    chk("wd_pre_error", 32'(error), 32'd0);
    tick();
    chk("wd_state", 32'(state), 32'd5);
    chk("wd_error", 32'(error), 32'd1);
    chk("wd_v1", 32'(v1_areset_n), 32'd0);
    chk("wd_busy", 32'(busy), 32'd0);
    channel_mask = 2'b01;
    cmd_run      = 1'b1;
    tick();
    cmd_run      = 1'b0;
    chk("wd_rerun_state", 32'(state), 32'd1);
    chk("wd_rerun_error", 32'(error), 32'd0);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
